// File: rtl/tb_mem_ctrl_pkg.sv
// Shared definitions for the traceback survivor-memory controller.
package tb_mem_ctrl_pkg;
  localparam int NBANK = 4;
  localparam int DEC_W = 8;

  typedef logic [$clog2(NBANK)-1:0] bank_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Bank that lies n positions behind b in the circular bank order.
  function automatic bank_t bank_back(input bank_t b, input bank_t n);
    return b - n;
  endfunction
endpackage

// File: rtl/tb_mem_ctrl_bank_ram.sv
// Survivor storage: NBANK x DEPTH decision words, one write port and two
// registered read ports. Array contents are deliberately left unreset.
module tb_bank_ram
  import tb_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  bank_t                    wbank,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DEC_W-1:0]         wdata,
  input  bank_t                    rbank_0,
  input  bank_t                    rbank_1,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DEC_W-1:0]         rdata_0,
  output logic [DEC_W-1:0]         rdata_1
);
  logic [DEC_W-1:0] mem [NBANK*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_0 <= '0;
      rdata_1 <= '0;
    end else begin
      rdata_0 <= mem[{rbank_0, raddr}];
      rdata_1 <= mem[{rbank_1, raddr}];
    end
  end
endmodule

// File: rtl/tb_mem_ctrl.sv
// Survivor-memory controller feeding two traceback units: writes ACS
// decisions bank by bank and reads completed banks back in reverse order.
//
// state   | meaning
// IDLE    | pointers cleared, waiting for the first decision word
// FILL    | writing the first three banks, traceback disabled
// RUN     | streaming; traceback enabled, sel_a alternates per bank
module tb_mem_ctrl
  import tb_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dec_valid,
  input  logic [DEC_W-1:0] dec_in,
  output logic [DEC_W-1:0] d_out_0,
  output logic [DEC_W-1:0] d_out_1,
  output logic             sel_a,
  output logic             tb_en,
  output logic             frame_start,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state;
  bank_t         wb;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [1:0]    fill_cnt;
  logic          phase;
  logic          wr;
  logic          wrap;
  logic          live;

  assign wr   = enable & dec_valid;
  assign wrap = wr && (wa == AW'(DEPTH - 1));
  assign live = wr && (state == ST_RUN);
  assign ra   = AW'(DEPTH - 1) - wa;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wa       <= '0;
      wb       <= '0;
      fill_cnt <= '0;
      phase    <= 1'b0;
      err      <= 1'b0;
    end else if (!enable) begin
      state    <= ST_IDLE;
      wa       <= '0;
      wb       <= '0;
      fill_cnt <= '0;
      phase    <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (wr) begin
        wa <= wa + 1'b1;
        if (wrap) wb <= wb + 1'b1;
      end
      case (state)
        ST_IDLE: if (wr) state <= ST_FILL;
        ST_FILL: begin
          // The wrap that completes the third bank enters RUN with phase still 0.
          if (wrap) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == 2'd2) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!dec_valid) begin
            state    <= ST_IDLE;
            err      <= 1'b1;
            wa       <= '0;
            wb       <= '0;
            fill_cnt <= '0;
            phase    <= 1'b0;
          end else if (wrap) begin
            phase <= ~phase;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flags share the read-port register stage so they line up with d_out_0/1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_en       <= 1'b0;
      frame_start <= 1'b0;
      sel_a       <= 1'b0;
    end else begin
      tb_en       <= live;
      frame_start <= live && (wa == '0);
      sel_a       <= live & phase;
    end
  end

  tb_bank_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr),
    .wbank   (wb),
    .waddr   (wa),
    .wdata   (dec_in),
    .rbank_0 (bank_back(wb, 2'd1)),
    .rbank_1 (bank_back(wb, 2'd3)),
    .raddr   (ra),
    .rdata_0 (d_out_0),
    .rdata_1 (d_out_1)
  );
endmodule

// File: tb/tb_tb_mem_ctrl.sv
// Self-checking bench for tb_mem_ctrl: streaming scoreboard, reverse-read
// table, underrun/refill, flush and asynchronous reset sequences.
module tb_tb_mem_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       dec_valid;
  logic [7:0] dec_in;
  logic [7:0] d_out_0;
  logic [7:0] d_out_1;
  logic       sel_a;
  logic       tb_en;
  logic       frame_start;
  logic       err;

  int errors = 0;
  int checks = 0;
  int wcnt   = 0;
  int edges;

  typedef struct {
    logic       te;
    logic       fs;
    logic       sa;
    bit         dk0;
    bit         dk1;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       te;
    logic       fs;
    logic       sa;
    logic       er;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  tb_mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .dec_valid   (dec_valid),
    .dec_in      (dec_in),
    .d_out_0     (d_out_0),
    .d_out_1     (d_out_1),
    .sel_a       (sel_a),
    .tb_en       (tb_en),
    .frame_start (frame_start),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value written for the w-th word of a stream: {bank, address} nibbles.
  function automatic logic [7:0] pat(input int w);
    return 8'((((w / DEPTH) % 4) * 16) + (w % DEPTH));
  endfunction

  // Most recent write index (1-based) among the first p words that landed at (bank, addr).
  function automatic int last_write(input int p, input int bank, input int addr);
    for (int m = p; m >= 1; m--)
      if ((((m - 1) / DEPTH) % 4) == bank && ((m - 1) % DEPTH) == addr) return m;
    return 0;
  endfunction

  // Stream pattern words (with an optional gap) until tb_en rises; edges counts clock edges used.
  task automatic refill(input int gap_at, input int gap_len, input logic exp_err, output int n);
    int gap = 0;
    int w = 0;
    n = 0;
    while (!tb_en && n < 100) begin
      enable = 1'b1;
      if (w == gap_at && gap < gap_len) begin
        dec_valid = 1'b0;
        gap++;
      end else begin
        dec_valid = 1'b1;
        dec_in = pat(w);
        w++;
      end
      tick();
      n++;
      chk("err_during_refill", err, exp_err);
    end
    wcnt = w;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{din: 8'(8'h20 + i), d0: 8'(8'h17 - i), d1: 8'(8'h37 - i),
                 te: 1'b1, fs: (i == 0), sa: 1'b1, er: 1'b1};

    rst = 1'b0; enable = 1'b0; dec_valid = 1'b0; dec_in = 8'h00;
    #2;
    chk("reset_d_out_0", d_out_0, 8'h00);
    chk("reset_d_out_1", d_out_1, 8'h00);
    chk("reset_tb_en", tb_en, 1'b0);
    chk("reset_sel_a", sel_a, 1'b0);
    chk("reset_frame_start", frame_start, 1'b0);
    chk("reset_err", err, 1'b0);
    #10 rst = 1'b1;
    tick();

    // Continuous stream from IDLE, dec_in = write index.
    for (int c = 1; c <= 80; c++) begin
      int   p;
      int   wa;
      int   wb;
      int   m0;
      int   m1;
      exp_t e;
      p  = c - 1;
      wa = p % DEPTH;
      wb = (p / DEPTH) % 4;
      enable = 1'b1; dec_valid = 1'b1; dec_in = 8'(c);
      e.te  = (c > 3 * DEPTH);
      e.fs  = (c > 3 * DEPTH) && (wa == 0);
      e.sa  = (c > 3 * DEPTH) && ((((p - 3 * DEPTH) / DEPTH) % 2) == 1);
      m0 = last_write(p, (wb + 3) % 4, DEPTH - 1 - wa);
      m1 = last_write(p, (wb + 1) % 4, DEPTH - 1 - wa);
      e.dk0 = (m0 > 0); e.d0 = 8'(m0);
      e.dk1 = (m1 > 0); e.d1 = 8'(m1);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk("stream_tb_en", tb_en, e.te);
      chk("stream_frame_start", frame_start, e.fs);
      chk("stream_sel_a", sel_a, e.sa);
      chk("stream_err", err, 1'b0);
      if (e.dk0) chk("stream_d_out_0", d_out_0, e.d0);
      if (e.dk1) chk("stream_d_out_1", d_out_1, e.d1);
    end

    // Underrun in RUN.
    dec_valid = 1'b0;
    tick();
    chk("underrun_err", err, 1'b1);
    chk("underrun_tb_en", tb_en, 1'b0);
    chk("underrun_sel_a", sel_a, 1'b0);
    chk("underrun_frame_start", frame_start, 1'b0);
    refill(-1, 0, 1'b1, edges);
    chk("underrun_refill_edges", edges, 3 * DEPTH + 1);

    // Advance to wb = 2 on the second lap, then check the reversed reads.
    for (int g = 0; g < 100 && wcnt < 6 * DEPTH; g++) begin
      dec_valid = 1'b1;
      dec_in = pat(wcnt);
      wcnt++;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      dec_valid = 1'b1;
      dec_in = tbl[i].din;
      tick();
      chk("table_d_out_0", d_out_0, tbl[i].d0);
      chk("table_d_out_1", d_out_1, tbl[i].d1);
      chk("table_tb_en", tb_en, tbl[i].te);
      chk("table_frame_start", frame_start, tbl[i].fs);
      chk("table_sel_a", sel_a, tbl[i].sa);
      chk("table_err", err, tbl[i].er);
    end

    // One-cycle flush with dec_valid still high.
    enable = 1'b0; dec_valid = 1'b1;
    tick();
    chk("flush_tb_en", tb_en, 1'b0);
    chk("flush_sel_a", sel_a, 1'b0);
    chk("flush_frame_start", frame_start, 1'b0);
    chk("flush_err", err, 1'b0);

    // Reset pulse part-way through FILL.
    enable = 1'b1;
    for (int w = 0; w < 10; w++) begin
      dec_in = pat(w);
      tick();
    end
    chk("fill_tb_en", tb_en, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("midfill_rst_d_out_0", d_out_0, 8'h00);
    chk("midfill_rst_d_out_1", d_out_1, 8'h00);
    chk("midfill_rst_tb_en", tb_en, 1'b0);
    chk("midfill_rst_err", err, 1'b0);
    #2 rst = 1'b1;
    refill(5, 3, 1'b0, edges);
    chk("gap_refill_edges", edges, 3 * DEPTH + 1 + 3);
    chk("restart_frame_start", frame_start, 1'b1);
    chk("restart_sel_a", sel_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
